prog_freq_divider: RTL and testbench
====================================

Name: prog_freq_divider

Overview:
- Parametrised, multi-channel successor to the fixed single-output frequency divider in the button/clocking path.
- Each channel divides clk_in by a runtime-programmable integer divisor and produces a near-50% duty output plus a one-cycle terminal-count tick.
- Divisor changes are glitch-free: they take effect only at a period boundary.
- Consumers are debounce samplers, LED/seven-segment scanners and slow FSM strobes. Consumers use the tick for logic enables and clk_out for pin outputs only.

Parameters:
- NUM_CH, 2, number of independent divider channels (>=1)
- CNT_W, 16, counter and divisor width in bits (>=2)
- DEFAULT_DIV, 4, divisor loaded into every channel at reset (2 .. 2^CNT_W-1)

Ports:
- clk_in  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- enable  input  NUM_CH  per-channel run enable
- div_val  input  NUM_CH*CNT_W  packed divisors; channel i uses bits [i*CNT_W +: CNT_W]
- load  input  NUM_CH  per-channel one-cycle strobe that captures div_val for that channel
- clk_out  output  NUM_CH  divided clock, registered
- tick  output  NUM_CH  one-cycle pulse in the last cycle of each period, registered
- busy  output  NUM_CH  high while a loaded divisor is pending and not yet applied

Behaviour:
- Per-channel state: cnt[CNT_W], div_reg[CNT_W], pend_div[CNT_W], pend_valid.
- Reset (asynchronous assert, synchronous release):
  - cnt=0, div_reg=DEFAULT_DIV, pend_div=0, pend_valid=0.
  - clk_out=0, tick=0, busy=0.
- Divisor clamp: a captured value of 0 or 1 is stored as 2. No other range checks apply.
- Counting, with enable=1 and D=div_reg:
  - cnt steps 0,1,...,D-1,0,...
  - Period is exactly D clk_in cycles.
- clk_out is a flop loaded from next-state logic, so that in every cycle clk_out == (cnt >= floor(D/2)).
  - Low for floor(D/2) cycles, then high for ceil(D/2) cycles.
  - Odd D gives a high phase one cycle longer than the low phase.
- tick is a flop, so that in every cycle tick == enable_d && (cnt == D-1).
  - Exactly one tick per period, coincident with the last high cycle of clk_out.
- enable=0:
  - On the next edge cnt=0, clk_out=0, tick=0, and the channel holds there.
  - A high phase may be truncated; this is accepted.
  - When enable returns to 1, counting restarts from cnt=0, so the first period is a full D cycles.
- load handling (per channel):
  - Channel enabled, cnt != D-1: pend_div <= clamp(div_val_i), pend_valid <= 1, busy=1 from the next cycle.
  - Channel enabled, load in the same cycle as cnt == D-1: the captured value goes directly to div_reg at that wrap. pend_valid stays 0.
  - Pending value with no load present: at the edge where cnt == D-1, div_reg <= pend_div, pend_valid <= 0, cnt <= 0.
  - Channel disabled: div_reg <= clamp(div_val_i) on the next edge, no pending stage, busy stays 0.
  - A second load while pending overwrites pend_div; the last value wins.
  - Load and enable deassertion in the same cycle: the disabled rule applies.
- busy == pend_valid.
- Channels are fully independent; no cross-channel phase alignment.
- Reset mid-operation clears everything immediately. A pending divisor is discarded.

Test Plan:
- Reset behaviour: reset=1 for 100 ns with enable=all-ones → clk_out=0, tick=0, busy=0. After release, ch0 (D=4) gives clk_out 0,0,1,1 repeating and a tick every 4th cycle, aligned with cnt=3.
- Odd divisor: with ch0 disabled, load div_val=5 then enable → clk_out low 2 cycles / high 3 cycles, period 5, one tick per period. Check over 20 periods.
- Glitch-free reprogram: ch1 runs D=10; pulse load with 3 at cnt=2 → busy=1 for cycles cnt=3..9. The current period completes at 10 cycles, the following periods are 3 cycles, and busy=0 after the wrap.
- Boundary strobes:
  - load=7 exactly at cnt==D-1 → the next period is 7 and busy never asserts.
  - load=0 → period 2.
  - load=1 → period 2.
- Back-to-back loads and enable toggles: load 8 then 6 while pending → the applied divisor is 6. Drop enable mid high phase → clk_out=0 on the next edge. Re-enable → a full-length first period.
- Async reset mid-period with a pending divisor → outputs go to 0 without waiting for a clock edge. After release, div_reg=DEFAULT_DIV and the pending value is gone.

Source files
------------

// File: rtl/prog_freq_divider.sv
// Multi-channel programmable clock divider with glitch-free divisor reload.
// Latency: clk_out/tick are registered and reflect the counter state of the current cycle; a new divisor applies at the next period boundary.
// Backpressure: none; a load arriving while a divisor is pending overwrites it (last value wins), busy flags the pending state.
//
// Ports:
//   clk_in   - system clock, all logic on rising edge
//   reset    - asynchronous active-high reset
//   enable   - per-channel run enable
//   div_val  - packed divisors, channel i at [i*CNT_W +: CNT_W]
//   load     - per-channel capture strobe for div_val
//   clk_out  - per-channel divided clock (low floor(D/2), high ceil(D/2))
//   tick     - per-channel one-cycle pulse in the last cycle of each period
//   busy     - per-channel flag: a loaded divisor waits for the period boundary
module prog_freq_divider #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH*CNT_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       load,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       busy
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] div_raw;
    logic [CNT_W-1:0] div_clamped;
    logic             wrap;

    assign div_raw     = div_val[i*CNT_W +: CNT_W];
    // Divisors below 2 cannot produce a toggling output; force them to 2.
    assign div_clamped = (div_raw < DIV_MIN) ? DIV_MIN : div_raw;
    // >= rather than == keeps the counter from running away should it ever
    // sit above the current divisor.
    assign wrap        = (cnt_q >= (div_q - ONE));

    always_comb begin
      cnt_d      = cnt_q;
      div_d      = div_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      clk_d      = 1'b0;
      tick_d     = 1'b0;

      if (!enable[i]) begin
        // Idle channel: no period in flight, so a load applies at once and
        // any value still waiting is superseded.
        cnt_d = '0;
        if (load[i]) begin
          div_d      = div_clamped;
          pend_vld_d = 1'b0;
        end
      end else if (wrap) begin
        cnt_d = '0;
        if (load[i]) begin
          // Load coincides with the boundary: apply directly.
          div_d      = div_clamped;
          pend_vld_d = 1'b0;
        end else if (pend_vld_q) begin
          div_d      = pend_q;
          pend_vld_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + ONE;
        if (load[i]) begin
          pend_d     = div_clamped;
          pend_vld_d = 1'b1;
        end
      end

      // Outputs are computed from next state so the registered values line
      // up with the counter value held during the same cycle.
      clk_d  = enable[i] && (cnt_d >= (div_d >> 1));
      tick_d = enable[i] && (cnt_d == (div_d - ONE));
    end

    always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
        cnt_q      <= '0;
        div_q      <= DIV_RST;
        pend_q     <= '0;
        pend_vld_q <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        div_q      <= div_d;
        pend_q     <= pend_d;
        pend_vld_q <= pend_vld_d;
        clk_q      <= clk_d;
        tick_q     <= tick_d;
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
    assign busy[i]    = pend_vld_q;
  end

endmodule

// File: tb/tb_prog_freq_divider.sv
// Directed bench for prog_freq_divider: expected per-cycle {clk_out,tick,busy}
// for one channel are queued as stimulus is driven and popped one per cycle.
// Expected waveforms follow from the divisor: low floor(D/2), high ceil(D/2), tick on last cycle.
module tb_prog_freq_divider;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 16;

  logic                    clk_in = 1'b0;
  logic                    reset;
  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH*CNT_W-1:0] div_val;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       busy;

  typedef struct {
    int         ch;
    logic [2:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk_in = ~clk_in;

  prog_freq_divider #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(4)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .enable (enable),
    .div_val(div_val),
    .load   (load),
    .clk_out(clk_out),
    .tick   (tick),
    .busy   (busy)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs for channel ch at counter value c of a period of length d.
  function automatic void push_cnt(input int ch, input int d, input int c, input bit b,
                                   input string tag);
    exp_t e;
    e.ch  = ch;
    e.exp = {(c >= d / 2), (c == d - 1), b};
    e.tag = tag;
    sb.push_back(e);
  endfunction

  // busy expected high from counter value busy_from onward (busy_from >= d: never).
  function automatic void push_period(input int ch, input int d, input int busy_from,
                                      input string tag);
    for (int c = 0; c < d; c++) push_cnt(ch, d, c, (c >= busy_from), tag);
  endfunction

  task automatic chk_now();
    exp_t e;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_underflow observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      chk(e.tag, {5'd0, clk_out[e.ch], tick[e.ch], busy[e.ch]}, {5'd0, e.exp});
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
    if (sb.size() > 0) chk_now();
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() > 0 && g < 2000) begin
      cyc();
      g++;
    end
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout observed=%0d expected=0", sb.size());
    end
  endtask

  task automatic set_div(input int ch, input int val);
    div_val[ch*CNT_W +: CNT_W] = CNT_W'(val);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with both channels enabled.
    reset   = 1'b1;
    enable  = 2'b11;
    load    = 2'b00;
    div_val = '0;
    #100;
    chk("rst_clk_out", {6'd0, clk_out}, 8'd0);
    chk("rst_tick",    {6'd0, tick},    8'd0);
    chk("rst_busy",    {6'd0, busy},    8'd0);
    @(posedge clk_in);
    #1;
    reset = 1'b0;

    // Default divisor 4 on ch0: 0,0,1,1 with tick at cnt=3.
    for (int p = 0; p < 3; p++) push_period(0, 4, 4, "ch0_d4");
    chk_now();
    drain();

    // Odd divisor 5 loaded while ch0 is disabled.
    enable[0] = 1'b0;
    push_cnt(0, 4, 0, 1'b0, "ch0_disable");
    cyc();
    load[0] = 1'b1;
    set_div(0, 5);
    push_cnt(0, 5, 0, 1'b0, "ch0_load_disabled");
    cyc();
    load[0]   = 1'b0;
    enable[0] = 1'b1;
    for (int p = 0; p < 20; p++) push_period(0, 5, 5, "ch0_d5");
    chk_now();
    drain();

    // ch1 to 10 via load with simultaneous disable, then reprogram to 3 at cnt=2.
    enable[1] = 1'b0;
    load[1]   = 1'b1;
    set_div(1, 10);
    push_cnt(1, 10, 0, 1'b0, "ch1_dis_load");
    cyc();
    load[1]   = 1'b0;
    enable[1] = 1'b1;
    push_period(1, 10, 3, "ch1_d10_pending");
    for (int p = 0; p < 3; p++) push_period(1, 3, 3, "ch1_d3");
    chk_now();
    cyc();
    cyc();
    load[1] = 1'b1;
    set_div(1, 3);
    cyc();
    load[1] = 1'b0;
    drain();

    // Load 7 exactly at the wrap: applied directly, busy stays low.
    load[1] = 1'b1;
    set_div(1, 7);
    for (int p = 0; p < 2; p++) push_period(1, 7, 7, "ch1_wrap_load7");
    cyc();
    load[1] = 1'b0;
    drain();

    // Load 1 at the wrap: clamped to 2.
    load[1] = 1'b1;
    set_div(1, 1);
    for (int p = 0; p < 3; p++) push_period(1, 2, 2, "ch1_load1_clamp");
    cyc();
    load[1] = 1'b0;
    drain();

    // Back to 9, then load 0 mid-period: pending, clamped to 2.
    load[1] = 1'b1;
    set_div(1, 9);
    push_period(1, 9, 5, "ch1_d9_pending0");
    for (int p = 0; p < 2; p++) push_period(1, 2, 2, "ch1_load0_clamp");
    cyc();
    load[1] = 1'b0;
    repeat (4) cyc();
    load[1] = 1'b1;
    set_div(1, 0);
    cyc();
    load[1] = 1'b0;
    drain();

    // Back-to-back loads 8 then 6 while pending: 6 wins.
    load[1] = 1'b1;
    set_div(1, 12);
    push_period(1, 12, 3, "ch1_d12_b2b");
    for (int p = 0; p < 2; p++) push_period(1, 6, 6, "ch1_last_wins6");
    cyc();
    load[1] = 1'b0;
    cyc();
    cyc();
    load[1] = 1'b1;
    set_div(1, 8);
    cyc();
    set_div(1, 6);
    cyc();
    load[1] = 1'b0;
    drain();

    // Drop enable in the high phase, hold, then re-enable for a full period.
    for (int c = 0; c < 4; c++) push_cnt(1, 6, c, 1'b0, "ch1_pre_drop");
    repeat (4) cyc();
    enable[1] = 1'b0;
    for (int k = 0; k < 3; k++) push_cnt(1, 6, 0, 1'b0, "ch1_disabled");
    repeat (3) cyc();
    enable[1] = 1'b1;
    for (int p = 0; p < 2; p++) push_period(1, 6, 6, "ch1_reenable");
    chk_now();
    drain();

    // Async reset mid-period with a pending divisor.
    load[1] = 1'b1;
    set_div(1, 11);
    for (int c = 0; c < 7; c++) push_cnt(1, 11, c, (c >= 2), "ch1_d11_pre_rst");
    cyc();
    load[1] = 1'b0;
    cyc();
    load[1] = 1'b1;
    set_div(1, 5);
    cyc();
    load[1] = 1'b0;
    repeat (4) cyc();
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_clk_out", {6'd0, clk_out}, 8'd0);
    chk("async_rst_tick",    {6'd0, tick},    8'd0);
    chk("async_rst_busy",    {6'd0, busy},    8'd0);
    repeat (3) @(posedge clk_in);
    #1;
    reset = 1'b0;
    for (int p = 0; p < 3; p++) push_period(1, 4, 4, "ch1_post_rst_d4");
    chk_now();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
